line_endpoint_loader: RTL and testbench

LINE_ENDPOINT_LOADER -- requirements
Module: line_endpoint_loader

---
 rtl/line_endpoint_loader.sv | 195 +++++++++++++++++++
 tb/tb_line_endpoint_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_endpoint_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_endpoint_loader: buffers endpoint sets and commits them in vblank so  |
// | the line sprite only sees frame-stable coordinates.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module line_endpoint_loader #(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int STALE_FRAMES = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        ep_valid_in,
  output logic        ep_ready_out,
  input  logic [10:0] ep_x1_in,
  input  logic [10:0] ep_x2_in,
  input  logic [9:0]  ep_y1_in,
  input  logic [9:0]  ep_y2_in,
  input  logic        ep_visible_in,
  output logic [10:0] x1_out,
  output logic [10:0] x2_out,
  output logic [9:0]  y1_out,
  output logic [9:0]  y2_out,
  output logic        line_active_out,
  output logic        sprite_rst_out,
  output logic [7:0]  drop_count_out
);

  localparam int STALE_W = $clog2(STALE_FRAMES + 1);

  localparam logic [10:0]        X_MAX     = 11'(H_ACTIVE - 1);
  localparam logic [9:0]         Y_MAX     = 10'(V_ACTIVE - 1);
  localparam logic [9:0]         V_TRIG    = 10'(V_ACTIVE);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_FRAMES);
  localparam logic [STALE_W-1:0] STALE_ONE = STALE_W'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               reload_cnt_q, reload_cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [10:0]        pend_x1_q, pend_x1_d;
  logic [10:0]        pend_x2_q, pend_x2_d;
  logic [9:0]         pend_y1_q, pend_y1_d;
  logic [9:0]         pend_y2_q, pend_y2_d;
  logic               pend_vis_q, pend_vis_d;
  logic [STALE_W-1:0] stale_q, stale_d;
  logic [10:0]        x1_q, x1_d;
  logic [10:0]        x2_q, x2_d;
  logic [9:0]         y1_q, y1_d;
  logic [9:0]         y2_q, y2_d;
  logic               line_active_q, line_active_d;
  logic               sprite_rst_q, sprite_rst_d;
  logic [7:0]         drop_q, drop_d;

  logic trigger;
  logic transfer;

  function automatic logic [10:0] clamp_x(input logic [10:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] v);
    return (v > Y_MAX) ? Y_MAX : v;
  endfunction

  assign ep_ready_out = (state_q != ST_COMMIT);
  assign trigger      = (vcount_in == V_TRIG) && (hcount_in == 11'd0);
  assign transfer     = ep_valid_in && ep_ready_out;

  always_comb begin
    state_d       = state_q;
    reload_cnt_d  = reload_cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_x1_d     = pend_x1_q;
    pend_x2_d     = pend_x2_q;
    pend_y1_d     = pend_y1_q;
    pend_y2_d     = pend_y2_q;
    pend_vis_d    = pend_vis_q;
    stale_d       = stale_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    line_active_d = line_active_q;
    drop_d        = drop_q;

    if (transfer) begin
      pend_x1_d    = clamp_x(ep_x1_in);
      pend_x2_d    = clamp_x(ep_x2_in);
      pend_y1_d    = clamp_y(ep_y1_in);
      pend_y2_d    = clamp_y(ep_y2_in);
      pend_vis_d   = ep_visible_in;
      pend_valid_d = 1'b1;
      if (pend_valid_q && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 8'd1;
      end
    end

    // A line left untouched for too many frames is blanked; coordinates stay.
    if (stale_q == STALE_MAX) begin
      line_active_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (trigger) begin
          if (pend_valid_q || transfer) begin
            state_d = ST_COMMIT;
          end else if (stale_q != STALE_MAX) begin
            stale_d = stale_q + STALE_ONE;
          end
        end
      end
      ST_COMMIT: begin
        x1_d          = pend_x1_q;
        x2_d          = pend_x2_q;
        y1_d          = pend_y1_q;
        y2_d          = pend_y2_q;
        line_active_d = pend_vis_q;
        stale_d       = '0;
        pend_valid_d  = 1'b0;
        reload_cnt_d  = 1'b0;
        state_d       = ST_RELOAD;
      end
      ST_RELOAD: begin
        // Two reload cycles cover the sprite's registered min/max stage.
        if (reload_cnt_q) begin
          state_d = ST_RUN;
        end else begin
          reload_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    sprite_rst_d = (state_d == ST_RELOAD);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_RUN;
      reload_cnt_q  <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_x1_q     <= '0;
      pend_x2_q     <= '0;
      pend_y1_q     <= '0;
      pend_y2_q     <= '0;
      pend_vis_q    <= 1'b0;
      stale_q       <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      line_active_q <= 1'b0;
      sprite_rst_q  <= 1'b1;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      reload_cnt_q  <= reload_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_x1_q     <= pend_x1_d;
      pend_x2_q     <= pend_x2_d;
      pend_y1_q     <= pend_y1_d;
      pend_y2_q     <= pend_y2_d;
      pend_vis_q    <= pend_vis_d;
      stale_q       <= stale_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      line_active_q <= line_active_d;
      sprite_rst_q  <= sprite_rst_d;
      drop_q        <= drop_d;
    end
  end

  assign x1_out          = x1_q;
  assign x2_out          = x2_q;
  assign y1_out          = y1_q;
  assign y2_out          = y2_q;
  assign line_active_out = line_active_q;
  assign sprite_rst_out  = sprite_rst_q;
  assign drop_count_out  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_line_endpoint_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_line_endpoint_loader: directed self-checking bench for the loader.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_line_endpoint_loader;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        ep_valid_in;
  logic        ep_ready_out;
  logic [10:0] ep_x1_in, ep_x2_in;
  logic [9:0]  ep_y1_in, ep_y2_in;
  logic        ep_visible_in;
  logic [10:0] x1_out, x2_out;
  logic [9:0]  y1_out, y2_out;
  logic        line_active_out;
  logic        sprite_rst_out;
  logic [7:0]  drop_count_out;

  int n_checks = 0;
  int n_errors = 0;

  line_endpoint_loader #(
    .H_ACTIVE    (1280),
    .V_ACTIVE    (720),
    .STALE_FRAMES(8)
  ) u_dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .ep_valid_in    (ep_valid_in),
    .ep_ready_out   (ep_ready_out),
    .ep_x1_in       (ep_x1_in),
    .ep_x2_in       (ep_x2_in),
    .ep_y1_in       (ep_y1_in),
    .ep_y2_in       (ep_y2_in),
    .ep_visible_in  (ep_visible_in),
    .x1_out         (x1_out),
    .x2_out         (x2_out),
    .y1_out         (y1_out),
    .y2_out         (y2_out),
    .line_active_out(line_active_out),
    .sprite_rst_out (sprite_rst_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [10:0] x1, input logic [10:0] x2,
                      input logic [9:0] y1, input logic [9:0] y2, input logic vis);
    ep_valid_in   = 1'b1;
    ep_x1_in      = x1;
    ep_x2_in      = x2;
    ep_y1_in      = y1;
    ep_y2_in      = y2;
    ep_visible_in = vis;
    tick();
    ep_valid_in   = 1'b0;
  endtask

  // Drive the single vblank trigger cycle, then move off it.
  task automatic trig_edge();
    vcount_in = 10'd720;
    hcount_in = 11'd0;
    tick();
    hcount_in = 11'd1;
  endtask

  task automatic end_frame();
    vcount_in = 10'd0;
    hcount_in = 11'd0;
    tick();
  endtask

  task automatic check_ep(input string tag, input int x1, input int x2, input int y1, input int y2);
    check_eq({tag, "_x1"}, 32'(x1_out), 32'(x1));
    check_eq({tag, "_x2"}, 32'(x2_out), 32'(x2));
    check_eq({tag, "_y1"}, 32'(y1_out), 32'(y1));
    check_eq({tag, "_y2"}, 32'(y2_out), 32'(y2));
  endtask

  initial begin
    rst_in        = 1'b0;
    hcount_in     = 11'd0;
    vcount_in     = 10'd0;
    ep_valid_in   = 1'b0;
    ep_x1_in      = '0;
    ep_x2_in      = '0;
    ep_y1_in      = '0;
    ep_y2_in      = '0;
    ep_visible_in = 1'b0;

    // Reset values
    tick(); tick(); tick();
    check_eq("rst_ready",  32'(ep_ready_out), 32'd1);
    check_eq("rst_sprite", 32'(sprite_rst_out), 32'd1);
    check_eq("rst_active", 32'(line_active_out), 32'd0);
    check_eq("rst_drop",   32'(drop_count_out), 32'd0);
    check_ep("rst", 0, 0, 0, 0);
    rst_in = 1'b1;
    tick();
    check_eq("rst_release_sprite", 32'(sprite_rst_out), 32'd0);

    // Mid-frame transfer held until the trigger
    vcount_in = 10'd100;
    hcount_in = 11'd50;
    send(11'd100, 11'd300, 10'd50, 10'd200, 1'b1);
    tick(); tick();
    check_ep("hold", 0, 0, 0, 0);
    check_eq("hold_active", 32'(line_active_out), 32'd0);
    trig_edge();
    check_eq("commit_ready", 32'(ep_ready_out), 32'd0);
    check_eq("commit_x1_unchanged", 32'(x1_out), 32'd0);
    tick();
    check_ep("c1", 100, 300, 50, 200);
    check_eq("c1_active", 32'(line_active_out), 32'd1);
    check_eq("c1_sprite0", 32'(sprite_rst_out), 32'd1);
    check_eq("c1_ready", 32'(ep_ready_out), 32'd1);
    tick();
    check_eq("c1_sprite1", 32'(sprite_rst_out), 32'd1);
    tick();
    check_eq("c1_sprite_end", 32'(sprite_rst_out), 32'd0);
    end_frame();

    // Three transfers in one frame: two drops
    vcount_in = 10'd300;
    send(11'd1, 11'd1, 10'd1, 10'd1, 1'b1);
    send(11'd2, 11'd2, 10'd2, 10'd2, 1'b1);
    send(11'd10, 11'd20, 10'd30, 10'd40, 1'b1);
    check_eq("drop2", 32'(drop_count_out), 32'd2);
    trig_edge(); tick(); tick(); tick();
    check_ep("c2", 10, 20, 30, 40);
    end_frame();

    // Clamping
    vcount_in = 10'd10;
    send(11'd1280, 11'd2000, 10'd719, 10'd1000, 1'b1);
    trig_edge(); tick(); tick(); tick();
    check_ep("clamp", 1279, 1279, 719, 719);
    end_frame();

    // Transfer on the trigger cycle itself
    vcount_in     = 10'd720;
    hcount_in     = 11'd0;
    send(11'd1, 11'd2, 10'd3, 10'd4, 1'b1);
    hcount_in     = 11'd1;
    check_eq("ontrig_ready", 32'(ep_ready_out), 32'd0);
    tick();
    check_ep("ontrig", 1, 2, 3, 4);
    check_eq("ontrig_ready_after", 32'(ep_ready_out), 32'd1);
    check_eq("ontrig_drop", 32'(drop_count_out), 32'd2);
    tick(); tick();
    end_frame();

    // Stale blanking after 8 empty frames
    for (int f = 0; f < 7; f++) begin
      trig_edge(); tick(); tick();
      end_frame();
    end
    check_eq("stale7_active", 32'(line_active_out), 32'd1);
    check_eq("stale7_sprite", 32'(sprite_rst_out), 32'd0);
    trig_edge(); tick(); tick();
    check_eq("stale8_active", 32'(line_active_out), 32'd0);
    check_ep("stale8", 1, 2, 3, 4);
    end_frame();
    send(11'd9, 11'd9, 10'd9, 10'd9, 1'b1);
    trig_edge(); tick(); tick(); tick();
    check_eq("revive_active", 32'(line_active_out), 32'd1);
    check_ep("revive", 9, 9, 9, 9);
    end_frame();

    // vcount skipping V_ACTIVE, and hcount!=0 on V_ACTIVE, give no trigger
    send(11'd50, 11'd60, 10'd70, 10'd80, 1'b1);
    vcount_in = 10'd719; hcount_in = 11'd0; tick();
    vcount_in = 10'd721; hcount_in = 11'd0; tick();
    vcount_in = 10'd720; hcount_in = 11'd5; tick();
    check_eq("skip_ready", 32'(ep_ready_out), 32'd1);
    check_eq("skip_sprite", 32'(sprite_rst_out), 32'd0);
    check_eq("skip_x1", 32'(x1_out), 32'd9);

    // Commit, then reset while in RELOAD with a new set pending
    trig_edge();
    check_eq("pre_rst_ready", 32'(ep_ready_out), 32'd0);
    tick();
    check_eq("pre_rst_x1", 32'(x1_out), 32'd50);
    send(11'd11, 11'd22, 10'd33, 10'd44, 1'b1);
    check_eq("reload_sprite", 32'(sprite_rst_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check_ep("midrst", 0, 0, 0, 0);
    check_eq("midrst_active", 32'(line_active_out), 32'd0);
    check_eq("midrst_drop", 32'(drop_count_out), 32'd0);
    check_eq("midrst_sprite", 32'(sprite_rst_out), 32'd1);
    check_eq("midrst_ready", 32'(ep_ready_out), 32'd1);
    tick();
    rst_in = 1'b1;
    tick();
    end_frame();
    trig_edge();
    check_eq("nocommit_ready", 32'(ep_ready_out), 32'd1);
    tick(); tick();
    check_eq("nocommit_sprite", 32'(sprite_rst_out), 32'd0);
    check_eq("nocommit_x1", 32'(x1_out), 32'd0);
    check_eq("nocommit_active", 32'(line_active_out), 32'd0);
    end_frame();

    // Drop counter saturation
    vcount_in = 10'd5;
    for (int i = 0; i < 300; i++) begin
      send(11'(i), 11'd0, 10'd0, 10'd0, 1'b0);
    end
    check_eq("drop_sat", 32'(drop_count_out), 32'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
